// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Pipeline sequencer for the fetch/decode/execute pipeline. Turns decode
//   hazard/redirect/trap flags and execute-stage resource status into the
//   hold/kill controls of the fe2de and de2ex pipeline registers and the
//   PC-select mux. Owns the multi-cycle mul/div wait and the data-memory wait.
//
// Parameters
//   MD_CYCLES : execute cycles an MD op occupies, counted from issue (2..63)
//   CNT_W     : MD down-counter width, must hold MD_CYCLES-1
//
// Ports
//   clk, rst            : core clock, synchronous active-high reset
//   de_valid            : decode slot holds a valid instruction
//   de_stall            : load-use hazard from decode
//   de_sl_conflict      : store->load conflict from decode
//   branch_predict_err  : decode branch resolution disagrees with prediction
//   de_exp / de_mret    : decode ecall/ebreak trap / mret
//   de_md_op            : decode mul/div op
//   ex_mem_en           : execute stage has a data-memory access
//   dmem_ready          : data memory accepts/completes the access this cycle
//   pc_hold             : fetch PC keeps its value
//   fe2de_hold/_kill    : fe2de register keeps its value / loads a bubble
//   de2ex_hold/_kill    : de2ex register keeps its value / loads a bubble
//   pc_sel              : 0 seq/predicted, 1 branch target, 2 trap vector, 3 mepc
//   md_busy             : MD op in progress
//   state_dbg           : current state encoding
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de_valid,
  input  logic       de_stall,
  input  logic       de_sl_conflict,
  input  logic       branch_predict_err,
  input  logic       de_exp,
  input  logic       de_mret,
  input  logic       de_md_op,
  input  logic       ex_mem_en,
  input  logic       dmem_ready,
  output logic       pc_hold,
  output logic       fe2de_hold,
  output logic       fe2de_kill,
  output logic       de2ex_hold,
  output logic       de2ex_kill,
  output logic [1:0] pc_sel,
  output logic       md_busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_DRAIN    = 2'd3
  } state_e;

  localparam logic [1:0] PC_SEQ  = 2'd0;
  localparam logic [1:0] PC_BR   = 2'd1;
  localparam logic [1:0] PC_TRAP = 2'd2;
  localparam logic [1:0] PC_MEPC = 2'd3;

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  // Decode flags only mean something when the decode slot is valid.
  logic mem_block, stall_hit, exp_hit, mret_hit, bpe_hit, md_hit;

  assign mem_block = ex_mem_en & ~dmem_ready;
  assign stall_hit = de_valid & (de_stall | de_sl_conflict);
  assign exp_hit   = de_valid & de_exp;
  assign mret_hit  = de_valid & de_mret;
  assign bpe_hit   = de_valid & branch_predict_err;
  assign md_hit    = de_valid & de_md_op;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // NOTE: every output and next-state signal gets a default at the top of the
  // block, so no path through the case leaves one unassigned (no latches).
  always_comb begin
    pc_hold    = 1'b0;
    fe2de_hold = 1'b0;
    fe2de_kill = 1'b0;
    de2ex_hold = 1'b0;
    de2ex_kill = 1'b0;
    pc_sel     = PC_SEQ;
    md_busy    = 1'b0;
    state_d    = state_q;
    md_cnt_d   = md_cnt_q;

    if (rst) begin
      // Flush both pipeline registers while reset is held, whatever state we
      // were in; the register process returns to RUN with a cleared counter.
      fe2de_kill = 1'b1;
      de2ex_kill = 1'b1;
      state_d    = ST_RUN;
      md_cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_block) begin
            // Memory wait freezes the whole pipe and masks every decode event.
            pc_hold    = 1'b1;
            fe2de_hold = 1'b1;
            de2ex_hold = 1'b1;
            state_d    = ST_MEM_WAIT;
          end else if (stall_hit) begin
            // Decode operands are stale: hold the front end, inject one bubble,
            // and ignore any redirect, trap or MD issue seen this cycle.
            pc_hold    = 1'b1;
            fe2de_hold = 1'b1;
            de2ex_kill = 1'b1;
          end else if (exp_hit || mret_hit) begin
            // Trap/mret instruction itself proceeds to execute; the fetch behind
            // it is wrong-path and so is the next one, flushed in DRAIN.
            pc_sel     = exp_hit ? PC_TRAP : PC_MEPC;
            fe2de_kill = 1'b1;
            state_d    = ST_DRAIN;
          end else if (bpe_hit) begin
            pc_sel     = PC_BR;
            fe2de_kill = 1'b1;
          end else if (md_hit) begin
            state_d  = ST_MD_WAIT;
            md_cnt_d = MD_LOAD;
          end
        end

        ST_MD_WAIT: begin
          md_busy  = 1'b1;
          md_cnt_d = md_cnt_q - CNT_ONE;
          if (md_cnt_q == CNT_ONE) begin
            // Completion cycle: holds drop so the result retires and the pipe
            // advances at the end of this cycle.
            state_d = ST_RUN;
          end else begin
            pc_hold    = 1'b1;
            fe2de_hold = 1'b1;
            de2ex_hold = 1'b1;
          end
        end

        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            state_d = ST_RUN;
          end else begin
            pc_hold    = 1'b1;
            fe2de_hold = 1'b1;
            de2ex_hold = 1'b1;
          end
        end

        ST_DRAIN: begin
          fe2de_kill = 1'b1;
          de2ex_kill = 1'b1;
          state_d    = ST_RUN;
        end

        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed self-checking bench for pipe_hazard_ctrl with MD_CYCLES=4.
//   Each step drives one cycle of inputs shortly after the rising edge, queues
//   the hand-written expected output vector, then pops and compares it against
//   the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int MD_CYCLES = 4;
  localparam int CNT_W     = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       de_valid, de_stall, de_sl_conflict, branch_predict_err;
  logic       de_exp, de_mret, de_md_op, ex_mem_en, dmem_ready;
  logic       pc_hold, fe2de_hold, fe2de_kill, de2ex_hold, de2ex_kill;
  logic [1:0] pc_sel;
  logic       md_busy;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MD_CYCLES(MD_CYCLES),
    .CNT_W    (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .de_valid          (de_valid),
    .de_stall          (de_stall),
    .de_sl_conflict    (de_sl_conflict),
    .branch_predict_err(branch_predict_err),
    .de_exp            (de_exp),
    .de_mret           (de_mret),
    .de_md_op          (de_md_op),
    .ex_mem_en         (ex_mem_en),
    .dmem_ready        (dmem_ready),
    .pc_hold           (pc_hold),
    .fe2de_hold        (fe2de_hold),
    .fe2de_kill        (fe2de_kill),
    .de2ex_hold        (de2ex_hold),
    .de2ex_kill        (de2ex_kill),
    .pc_sel            (pc_sel),
    .md_busy           (md_busy),
    .state_dbg         (state_dbg)
  );

  // Input vector bits: {rst, valid, stall, slc, bpe, exp, mret, md, mem, rdy}
  localparam logic [9:0] I_NONE  = 10'h000;
  localparam logic [9:0] I_RST   = 10'h200;
  localparam logic [9:0] I_VLD   = 10'h100;
  localparam logic [9:0] I_STALL = 10'h080;
  localparam logic [9:0] I_SLC   = 10'h040;
  localparam logic [9:0] I_BPE   = 10'h020;
  localparam logic [9:0] I_EXP   = 10'h010;
  localparam logic [9:0] I_MRET  = 10'h008;
  localparam logic [9:0] I_MD    = 10'h004;
  localparam logic [9:0] I_MEM   = 10'h002;
  localparam logic [9:0] I_RDY   = 10'h001;

  // Output vector bits: {pc_hold, fe2de_hold, fe2de_kill, de2ex_hold,
  //                      de2ex_kill, pc_sel[1:0], md_busy, state_dbg[1:0]}
  localparam logic [9:0] O_NONE = 10'h000;
  localparam logic [9:0] O_PH   = 10'h200;
  localparam logic [9:0] O_FH   = 10'h100;
  localparam logic [9:0] O_FK   = 10'h080;
  localparam logic [9:0] O_DH   = 10'h040;
  localparam logic [9:0] O_DK   = 10'h020;
  localparam logic [9:0] O_BUSY = 10'h004;
  localparam logic [9:0] HOLDS  = O_PH | O_FH | O_DH;
  localparam logic [9:0] KILLS  = O_FK | O_DK;
  localparam logic [9:0] SEL1   = 10'h008;
  localparam logic [9:0] SEL2   = 10'h010;
  localparam logic [9:0] SEL3   = 10'h018;
  localparam logic [9:0] S_MD   = 10'h001;
  localparam logic [9:0] S_MW   = 10'h002;
  localparam logic [9:0] S_DR   = 10'h003;

  typedef struct {
    string      tag;
    logic [9:0] exp_v;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        checks = 0;
  int        errors = 0;

  function automatic logic [9:0] observed();
    return {pc_hold, fe2de_hold, fe2de_kill, de2ex_hold, de2ex_kill,
            pc_sel, md_busy, state_dbg};
  endfunction

  // One clock cycle: drive inputs after the edge, queue the expectation,
  // compare on the falling edge once combinational outputs have settled.
  task automatic step(input string tag, input logic [9:0] in_v,
                      input logic [9:0] exp_v, input bit chk);
    sb_entry_t e;
    logic [9:0] obs;
    @(posedge clk);
    #1;
    {rst, de_valid, de_stall, de_sl_conflict, branch_predict_err,
     de_exp, de_mret, de_md_op, ex_mem_en, dmem_ready} = in_v;
    if (chk) begin
      e.tag   = tag;
      e.exp_v = exp_v;
      sb_q.push_back(e);
    end
    @(negedge clk);
    if (chk) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s: scoreboard empty", tag);
      end else begin
        e   = sb_q.pop_front();
        obs = observed();
        assert (obs === e.exp_v) else begin
          errors++;
          $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp_v);
        end
      end
    end
  endtask

  initial begin
    {rst, de_valid, de_stall, de_sl_conflict, branch_predict_err,
     de_exp, de_mret, de_md_op, ex_mem_en, dmem_ready} = I_RST;

    // Power-up reset; state is unknown before the first edge.
    step("rst0",        I_RST,           O_NONE,              1'b0);
    step("rst_kills",   I_RST,           KILLS,               1'b1);
    step("idle",        I_NONE,          O_NONE,              1'b1);

    // MD op: issue, then MD_CYCLES-1 wait cycles; last one releases holds.
    step("md_issue",    I_VLD | I_MD,    O_NONE,              1'b1);
    step("md_w3",       I_NONE,          HOLDS | O_BUSY | S_MD, 1'b1);
    step("md_w2",       I_NONE,          HOLDS | O_BUSY | S_MD, 1'b1);
    step("md_done",     I_NONE,          O_BUSY | S_MD,       1'b1);
    step("md_run",      I_NONE,          O_NONE,              1'b1);

    // Reset mid-MD_WAIT, then a fresh MD op must see the full count again.
    step("md2_issue",   I_VLD | I_MD,    O_NONE,              1'b1);
    step("md2_w3",      I_NONE,          HOLDS | O_BUSY | S_MD, 1'b1);
    step("md_rst1",     I_RST,           KILLS | S_MD,        1'b1);
    step("md_rst2",     I_RST,           KILLS,               1'b1);
    step("md_rst_run",  I_NONE,          O_NONE,              1'b1);
    step("md3_issue",   I_VLD | I_MD,    O_NONE,              1'b1);
    step("md3_w3",      I_NONE,          HOLDS | O_BUSY | S_MD, 1'b1);
    step("md3_w2",      I_NONE,          HOLDS | O_BUSY | S_MD, 1'b1);
    step("md3_done",    I_NONE,          O_BUSY | S_MD,       1'b1);
    step("md3_run",     I_NONE,          O_NONE,              1'b1);

    // Stall masks mispredict; redirect follows once stall clears.
    step("stall_bpe",   I_VLD | I_STALL | I_BPE, O_PH | O_FH | O_DK, 1'b1);
    step("bpe",         I_VLD | I_BPE,   SEL1 | O_FK,         1'b1);
    step("bpe_run",     I_NONE,          O_NONE,              1'b1);

    // Store->load conflict masks a trap.
    step("slc_exp",     I_VLD | I_SLC | I_EXP, O_PH | O_FH | O_DK, 1'b1);
    step("slc_run",     I_NONE,          O_NONE,              1'b1);

    // Trap beats mispredict; one DRAIN cycle follows.
    step("exp_bpe",     I_VLD | I_EXP | I_BPE, SEL2 | O_FK,   1'b1);
    step("exp_drain",   I_NONE,          KILLS | S_DR,        1'b1);
    step("exp_run",     I_NONE,          O_NONE,              1'b1);

    // mret: mepc select, DRAIN, RUN, no MD activity.
    step("mret",        I_VLD | I_MRET,  SEL3 | O_FK,         1'b1);
    step("mret_drain",  I_NONE,          KILLS | S_DR,        1'b1);
    step("mret_run",    I_NONE,          O_NONE,              1'b1);

    // Decode flags without de_valid have no effect.
    step("novalid",     I_STALL | I_BPE | I_EXP | I_MD, O_NONE, 1'b1);
    step("novalid_run", I_NONE,          O_NONE,              1'b1);

    // Memory wait masks a trap; released in the ready cycle.
    step("mem_blk",     I_VLD | I_EXP | I_MEM, HOLDS,         1'b1);
    step("mem_w1",      I_MEM,           HOLDS | S_MW,        1'b1);
    step("mem_w2",      I_MEM,           HOLDS | S_MW,        1'b1);
    step("mem_rdy",     I_MEM | I_RDY,   S_MW,                1'b1);
    step("mem_run",     I_NONE,          O_NONE,              1'b1);

    // Memory access ready immediately: no wait at all.
    step("mem_fast",    I_MEM | I_RDY,   O_NONE,              1'b1);

    // Reset mid-MEM_WAIT.
    step("mw_enter",    I_MEM,           HOLDS,               1'b1);
    step("mw_rst",      I_RST | I_MEM,   KILLS | S_MW,        1'b1);
    step("mw_rst_run",  I_MEM | I_RDY,   O_NONE,              1'b1);

    // Stall masks MD issue.
    step("stall_md",    I_VLD | I_STALL | I_MD, O_PH | O_FH | O_DK, 1'b1);
    step("stall_md_run", I_NONE,         O_NONE,              1'b1);

    // Trap beats MD issue; DRAIN ignores new decode events.
    step("exp_md",      I_VLD | I_EXP | I_MD, SEL2 | O_FK,    1'b1);
    step("drain_ign",   I_VLD | I_EXP,   KILLS | S_DR,        1'b1);
    step("drain_run",   I_NONE,          O_NONE,              1'b1);

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
